// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// controller state enumeration and the default attached-memory depth.
package load_store_unit_pkg;

  // Encoding of req_size
  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  // Controller states
  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_e;

  // Default word count of the attached memory (64 KiB)
  localparam int unsigned MEM_WORDS_DEFAULT = 16384;

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: purely combinational lane handling for the load/store unit.
//   size        access size of the latched request
//   offset      byte offset within the word (addr[1:0])
//   is_unsigned zero-extend loads when 1, sign-extend when 0
//   rdata       word read from memory
//   old_word    previously captured word (read-modify-write base)
//   wdata       right-aligned store data
//   load_data   selected little-endian lane, extended to 32 bits
//   store_word  old_word with the addressed lanes replaced by wdata
module lsu_align
  import load_store_unit_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata[7:0];
    unique case (offset)
      2'd0: sel_byte = rdata[7:0];
      2'd1: sel_byte = rdata[15:8];
      2'd2: sel_byte = rdata[23:16];
      2'd3: sel_byte = rdata[31:24];
    endcase
    sel_half = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = '0;
    unique case (size)
      SIZE_BYTE:    load_data = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
      SIZE_HALF:    load_data = {{16{~is_unsigned & sel_half[15]}}, sel_half};
      SIZE_WORD:    load_data = rdata;
      SIZE_ILLEGAL: load_data = '0;
    endcase
  end

  always_comb begin
    store_word = old_word;
    unique case (size)
      SIZE_BYTE: begin
        unique case (offset)
          2'd0: store_word[7:0]   = wdata[7:0];
          2'd1: store_word[15:8]  = wdata[7:0];
          2'd2: store_word[23:16] = wdata[7:0];
          2'd3: store_word[31:24] = wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (offset[1]) store_word[31:16] = wdata[15:0];
        else           store_word[15:0]  = wdata[15:0];
      end
      SIZE_WORD:    store_word = wdata;
      SIZE_ILLEGAL: store_word = old_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-request load/store controller in front of a
// word-wide memory with combinational read data.
//   clock, reset         rising-edge clock, synchronous active-high reset
//   req_*                request handshake and fields (latched on accept)
//   resp_valid/rdata/error  one-cycle registered completion
//   mem_address/write_data/writeEn/read_data  word memory port
// Loads: IDLE->READ->RESP. Word stores: IDLE->WRITE->RESP.
// Sub-word stores: IDLE->READ->WRITE->RESP (read-modify-write).
// Rejected requests: IDLE->RESP with resp_error, no memory access.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_writeEn,
  input  logic [31:0] mem_read_data
);

  // One past the last legal byte address, widened so it cannot wrap.
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  state_e      state, next_state;
  logic        lat_write, lat_unsigned;
  size_e       lat_size;
  logic [31:0] lat_addr, lat_wdata, old_word;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic        accept, req_error;
  logic [31:0] load_data, store_word;

  assign accept = req_valid && (state == IDLE);

  // Request legality, evaluated on the live request fields at acceptance.
  always_comb begin
    req_error = 1'b0;
    unique case (size_e'(req_size))
      SIZE_BYTE:    req_error = 1'b0;
      SIZE_HALF:    req_error = req_addr[0];
      SIZE_WORD:    req_error = |req_addr[1:0];
      SIZE_ILLEGAL: req_error = 1'b1;
    endcase
    if ({1'b0, req_addr} >= ADDR_LIMIT) req_error = 1'b1;
  end

  // Next state plus the values the response registers take on entering RESP;
  // they default to zero so the registered outputs are clear outside RESP.
  always_comb begin
    next_state = state;
    rdata_d    = '0;
    error_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_error) begin
            next_state = RESP;
            error_d    = 1'b1;
          end else if (!req_write) begin
            next_state = READ;
          end else if (size_e'(req_size) == SIZE_WORD) begin
            next_state = WRITE;
          end else begin
            next_state = READ;
          end
        end
      end
      READ: begin
        if (lat_write) begin
          next_state = WRITE;
        end else begin
          next_state = RESP;
          rdata_d    = load_data;
        end
      end
      WRITE: next_state = RESP;
      RESP:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state   <= next_state;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Request fields and the read-modify-write base need no reset: they are
  // only consumed after an acceptance or a READ cycle has loaded them.
  always_ff @(posedge clock) begin
    if (accept) begin
      lat_write    <= req_write;
      lat_size     <= size_e'(req_size);
      lat_unsigned <= req_unsigned;
      lat_addr     <= req_addr;
      lat_wdata    <= req_wdata;
    end
    if (state == READ) old_word <= mem_read_data;
  end

  lsu_align u_align (
    .size        (lat_size),
    .offset      (lat_addr[1:0]),
    .is_unsigned (lat_unsigned),
    .rdata       (mem_read_data),
    .old_word    (old_word),
    .wdata       (lat_wdata),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  assign req_ready      = (state == IDLE);
  assign resp_valid     = (state == RESP);
  assign resp_rdata     = rdata_q;
  assign resp_error     = error_q;
  assign mem_address    = (state == READ || state == WRITE) ? {lat_addr[31:2], 2'b00} : '0;
  // Gating with reset kills an in-flight store in the same cycle reset rises.
  assign mem_writeEn    = (state == WRITE) && !reset;
  assign mem_write_data = (state == WRITE) ? store_word : '0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_writeEn;
  logic [31:0] mem_read_data;

  int checks = 0;
  int errors = 0;

  // Attached memory with a backdoor preload port.
  logic [31:0] env_mem [0:16383];
  logic        pl_en = 1'b0;
  logic [13:0] pl_idx = '0;
  logic [31:0] pl_data = '0;

  // Reference memory image kept by the model.
  bit [31:0] ref_mem [int];

  always #5 clock = ~clock;

  assign mem_read_data = env_mem[mem_address[15:2]];

  always @(posedge clock) begin
    if (mem_writeEn) env_mem[mem_address[15:2]] <= mem_write_data;
    else if (pl_en)  env_mem[pl_idx] <= pl_data;
  end

  load_store_unit #(.MEM_WORDS(16384)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_writeEn    (mem_writeEn),
    .mem_read_data  (mem_read_data)
  );

  // ---------------- reference model ----------------
  function automatic int nbytes(bit [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_err(bit [1:0] sz, bit [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) ||
           (sz == 2'd2 && a % 4 != 0) || (a >= 32'd65536);
  endfunction

  function automatic bit [31:0] model_load(bit [31:0] word, bit [1:0] sz, bit uns, bit [31:0] a);
    longint span = longint'(1) << (8 * nbytes(sz));
    longint v = (longint'(word) >> (8 * (a % 4))) % span;
    if (!uns && nbytes(sz) < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic bit [31:0] model_store(bit [31:0] old, bit [1:0] sz, bit [31:0] a, bit [31:0] wd);
    longint sh = 8 * (a % 4);
    longint mask = ((longint'(1) << (8 * nbytes(sz))) - 1) << sh;
    longint r = (longint'(old) & ~mask) | ((longint'(wd) << sh) & mask);
    return r[31:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic preload(input bit [31:0] a, input bit [31:0] d);
    @(negedge clock);
    pl_en = 1'b1; pl_idx = a[15:2]; pl_data = d;
    @(posedge clock); #1;
    pl_en = 1'b0;
    ref_mem[int'(a[15:2])] = d;
  endtask

  // Issues one request from IDLE; lat is the cycle (acceptance = 1) in which
  // resp_valid was seen, 0 if none appeared within the budget.
  task automatic run_req(input bit w, input bit [1:0] sz, input bit u, input bit [31:0] a,
                         input bit [31:0] wd, output int lat, output bit [31:0] rd,
                         output bit er, output int wr_pulses, output bit [31:0] wr_addr,
                         output bit leak);
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 0; rd = '0; er = 1'b0; wr_pulses = 0; wr_addr = '0; leak = 1'b0;
    for (int k = 2; k <= 10 && lat == 0; k++) begin
      @(negedge clock);
      if (mem_writeEn) begin wr_pulses++; wr_addr = mem_address; end
      if (resp_valid) begin lat = k; rd = resp_rdata; er = resp_error; end
      else if (resp_rdata != 0 || resp_error) leak = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h40;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
    checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", resp_error); end
    checks++; if (mem_writeEn !== 1'b0) begin errors++; $display("FAIL reset_writeEn: got %b expected 0", mem_writeEn); end
    checks++; if (mem_address !== 32'h0) begin errors++; $display("FAIL reset_address: got %h expected 0", mem_address); end
    req_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_loads();
    bit [1:0]  szs  [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    bit        us   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit [31:0] ads  [6] = '{32'h21, 32'h22, 32'h22, 32'h22, 32'h22, 32'h20};
    bit [31:0] exps [6] = '{32'h0000007F, 32'hFFFFFFFF, 32'h000000FF,
                            32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01};
    int lat, wp; bit [31:0] rd, wa; bit er, leak;
    preload(32'h20, 32'h80FF7F01);
    for (int i = 0; i < 6; i++) begin
      run_req(1'b0, szs[i], us[i], ads[i], 32'h0, lat, rd, er, wp, wa, leak);
      checks++; if (rd !== exps[i]) begin errors++; $display("FAIL load%0d_rdata: got %h expected %h", i, rd, exps[i]); end
      checks++; if (lat != 3) begin errors++; $display("FAIL load%0d_latency: got %0d expected 3", i, lat); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL load%0d_error: got %b expected 0", i, er); end
      checks++; if (wp != 0) begin errors++; $display("FAIL load%0d_writes: got %0d expected 0", i, wp); end
      checks++; if (leak) begin errors++; $display("FAIL load%0d_resp_outside: got nonzero expected 0", i); end
    end
  endtask

  task automatic test_stores();
    bit [1:0]  szs  [3] = '{2'd0, 2'd1, 2'd2};
    bit [31:0] ads  [3] = '{32'h11, 32'h12, 32'h14};
    bit [31:0] wds  [3] = '{32'h000000AB, 32'h0000BEEF, 32'hCAFEF00D};
    bit [31:0] expw [3] = '{32'h1122AB44, 32'hBEEFAB44, 32'hCAFEF00D};
    int        expl [3] = '{4, 4, 3};
    int lat, wp; bit [31:0] rd, wa; bit er, leak;
    preload(32'h10, 32'h11223344);
    preload(32'h14, 32'h55667788);
    for (int i = 0; i < 3; i++) begin
      run_req(1'b1, szs[i], 1'b0, ads[i], wds[i], lat, rd, er, wp, wa, leak);
      ref_mem[int'(ads[i][15:2])] = expw[i];
      checks++; if (env_mem[ads[i][15:2]] !== expw[i]) begin errors++; $display("FAIL store%0d_word: got %h expected %h", i, env_mem[ads[i][15:2]], expw[i]); end
      checks++; if (wp != 1) begin errors++; $display("FAIL store%0d_writes: got %0d expected 1", i, wp); end
      checks++; if (wa !== {ads[i][31:2], 2'b00}) begin errors++; $display("FAIL store%0d_address: got %h expected %h", i, wa, {ads[i][31:2], 2'b00}); end
      checks++; if (lat != expl[i]) begin errors++; $display("FAIL store%0d_latency: got %0d expected %0d", i, lat, expl[i]); end
      checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL store%0d_resp: got rdata %h error %b expected 0 0", i, rd, er); end
    end
  endtask

  task automatic test_errors();
    bit        ws  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bit [1:0]  szs [7] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd1, 2'd2, 2'd0};
    bit [31:0] ads [7] = '{32'h06, 32'h03, 32'h08, 32'h10000, 32'h05, 32'h0A, 32'h10000};
    int lat, wp; bit [31:0] rd, wa; bit er, leak;
    for (int j = 0; j < 4; j++) preload(32'(j * 4), 32'hA5A50000 + 32'(j));
    for (int i = 0; i < 7; i++) begin
      run_req(ws[i], szs[i], 1'b0, ads[i], 32'hFFFFFFFF, lat, rd, er, wp, wa, leak);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL err%0d_flag: got %b expected 1", i, er); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err%0d_rdata: got %h expected 0", i, rd); end
      checks++; if (lat != 2) begin errors++; $display("FAIL err%0d_latency: got %0d expected 2", i, lat); end
      checks++; if (wp != 0) begin errors++; $display("FAIL err%0d_writes: got %0d expected 0", i, wp); end
      if (ads[i] < 32'h10000) begin
        checks++; if (env_mem[ads[i][15:2]] !== ref_mem[int'(ads[i][15:2])]) begin errors++; $display("FAIL err%0d_memory: got %h expected %h", i, env_mem[ads[i][15:2]], ref_mem[int'(ads[i][15:2])]); end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    bit seen_resp = 1'b0, seen_wr = 1'b0;
    preload(32'h40, 32'h01234567);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
    @(posedge clock); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (mem_writeEn !== 1'b0) begin errors++; $display("FAIL rst_write_suppress: got %b expected 0", mem_writeEn); end
    @(posedge clock); #1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (resp_valid) seen_resp = 1'b1;
      if (mem_writeEn) seen_wr = 1'b1;
    end
    checks++; if (seen_resp) begin errors++; $display("FAIL rst_no_resp: got resp_valid 1 expected 0"); end
    checks++; if (seen_wr) begin errors++; $display("FAIL rst_no_write: got mem_writeEn 1 expected 0"); end
    checks++; if (env_mem[16] !== 32'h01234567) begin errors++; $display("FAIL rst_memory: got %h expected 01234567", env_mem[16]); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_back_to_back();
    bit [1:0]  szs [3] = '{2'd0, 2'd1, 2'd2};
    bit        us  [3] = '{1'b0, 1'b1, 1'b0};
    bit [31:0] ads [3] = '{32'h21, 32'h22, 32'h20};
    bit [31:0] expq[$];
    bit [31:0] got[$];
    int acc[$];
    int n = 0, lows = 0;
    for (int i = 0; i < 3; i++) expq.push_back(model_load(ref_mem[int'(ads[i][15:2])], szs[i], us[i], ads[i]));
    for (int c = 0; c < 30 && got.size() < 3; c++) begin
      @(negedge clock);
      if (resp_valid) got.push_back(resp_rdata);
      if (req_ready) begin
        if (n < 3) begin
          req_valid = 1'b1; req_write = 1'b0; req_size = szs[n]; req_unsigned = us[n]; req_addr = ads[n];
          acc.push_back(c);
          n++;
        end else req_valid = 1'b0;
      end else if (n > 0 && n < 3) lows++;
    end
    req_valid = 1'b0;
    checks++; if (acc.size() != 3 || got.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d accepts %0d responses expected 3 3", acc.size(), got.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (got[i] !== expq[i]) begin errors++; $display("FAIL b2b_rdata%0d: got %h expected %h", i, got[i], expq[i]); end
      end
      checks++; if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin errors++; $display("FAIL b2b_spacing: got %0d %0d expected 3 3", acc[1] - acc[0], acc[2] - acc[1]); end
    end
    checks++; if (lows != 4) begin errors++; $display("FAIL b2b_ready_low: got %0d expected 4", lows); end
  endtask

  task automatic test_random();
    int lat, wp, e_lat, idx; bit [31:0] rd, wa, a, wd, e_rd; bit er, leak, w, u, e_er; bit [1:0] sz;
    for (int j = 0; j < 16; j++) preload(32'h100 + 32'(j * 4), $urandom);
    for (int i = 0; i < 80; i++) begin
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 15) == 0) ? 32'h10000 + $urandom_range(0, 255) : 32'h100 + $urandom_range(0, 63);
      wd = $urandom;
      idx = int'(a[15:2]);
      e_er  = model_err(sz, a);
      e_lat = e_er ? 2 : (!w ? 3 : (sz == 2'd2 ? 3 : 4));
      e_rd  = (!e_er && !w) ? model_load(ref_mem[idx], sz, u, a) : 32'h0;
      if (!e_er && w) ref_mem[idx] = model_store(ref_mem[idx], sz, a, wd);
      run_req(w, sz, u, a, wd, lat, rd, er, wp, wa, leak);
      checks++; if (rd !== e_rd) begin errors++; $display("FAIL rnd%0d_rdata: got %h expected %h", i, rd, e_rd); end
      checks++; if (er !== e_er) begin errors++; $display("FAIL rnd%0d_error: got %b expected %b", i, er, e_er); end
      checks++; if (lat != e_lat) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, e_lat); end
      checks++; if (wp != ((w && !e_er) ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_writes: got %0d expected %0d", i, wp, (w && !e_er) ? 1 : 0); end
      checks++; if (leak) begin errors++; $display("FAIL rnd%0d_resp_outside: got nonzero expected 0", i); end
      if (a < 32'h10000) begin
        checks++; if (env_mem[a[15:2]] !== ref_mem[idx]) begin errors++; $display("FAIL rnd%0d_memory: got %h expected %h", i, env_mem[a[15:2]], ref_mem[idx]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_WORDS, default 16384, SHALL set the word count of the attached memory; legal byte addresses are 0..MEM_WORDS*4-1.
REQ-002 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  block can accept a request.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  in  1  zero-extend loads when 1; sign-extend when 0.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 resp_error  out  1  misaligned, illegal-size or out-of-range request.
REQ-014 mem_address  out  32  word-aligned byte address to the word memory.
REQ-015 mem_write_data  out  32  full word to write.
REQ-016 mem_writeEn  out  1  memory write strobe.
REQ-017 mem_read_data  in  32  combinational read data for mem_address.

Function
REQ-018 FSM states SHALL be IDLE, READ, WRITE, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid && req_ready, and all req_* fields are latched.
REQ-020 Error check at acceptance: half with addr[0]=1, word with addr[1:0]!=0, size 11, or addr>=MEM_WORDS*4 -> IDLE->RESP with resp_error=1 and no memory access.
REQ-021 Load: IDLE->READ->RESP; in READ, mem_read_data is captured, the byte/half at addr[1:0] is selected little-endian, and it is extended per req_unsigned.
REQ-022 Word store: IDLE->WRITE->RESP; mem_write_data = req_wdata.
REQ-023 Byte/half store: IDLE->READ->WRITE->RESP; READ captures the old word; WRITE writes it with only the addressed byte/half lanes replaced (read-modify-write).
REQ-024 mem_writeEn SHALL be 1 only in WRITE and only while reset=0, exactly one cycle per accepted store.
REQ-025 mem_address SHALL be {req_addr[31:2],2'b00} in READ and WRITE, and 0 in IDLE and RESP.
REQ-026 resp_valid SHALL be 1 for exactly the single RESP cycle; RESP->IDLE unconditionally.
REQ-027 Cycles from acceptance cycle to resp_valid inclusive: load 3, word store 3, sub-word store 4, error 2.
REQ-028 resp_rdata and resp_error are registered and SHALL be 0 outside RESP.
REQ-029 req_valid in non-IDLE states SHALL be ignored with no side effects.

Reset
REQ-030 reset=1 SHALL force state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_writeEn=0, and mem_address=0 on the next edge.
REQ-031 reset asserted mid-operation SHALL abandon the request with no response; a write in progress is suppressed combinationally.

Structure
REQ-032 A shared package SHALL hold the size encodings, the state enum and the MEM_WORDS default.
REQ-033 Lane extract/extend and lane merge SHALL live in one combinational sub-module, lsu_align.

Verification
REQ-034 Preload word 0x80FF7F01 at 0x20: lb 0x21->0x0000007F; lb 0x22->0xFFFFFFFF; lbu 0x22->0x000000FF; lh 0x22->0xFFFF80FF; lhu 0x22->0x000080FF; lw 0x20->0x80FF7F01.
REQ-035 Word 0x11223344 at 0x10: sb 0xAB to 0x11 -> word 0x1122AB44, exactly one mem_writeEn pulse, resp_valid on 4th cycle; sh 0xBEEF to 0x12 -> 0xBEEFAB44.
REQ-036 lw 0x06, lh 0x03, size 11, lw 0x10000 -> resp_error=1, resp_rdata=0, resp_valid on 2nd cycle, no mem_writeEn, memory unchanged.
REQ-037 sw 0xDEADBEEF to 0x40 with reset asserted in the WRITE cycle -> mem_writeEn=0, no resp_valid, word at 0x40 unchanged, req_ready=1 after reset release.
REQ-038 req_valid held high with 3 queued loads -> one acceptance every 3 cycles, in order, req_ready low between acceptances.
